// File: rtl/rv32i_types.sv
// Shared RV32I core types: CDB payload record and writeback-collector defaults.
`default_nettype none

package rv32i_types;

  localparam int CDB_ROB_ID_W     = 8;
  localparam int CDB_PREG_W       = 6;
  localparam int CDB_DATA_W       = 32;
  localparam int MUL_Q_DEPTH_DFLT = 4;

  typedef struct packed {
    logic [CDB_ROB_ID_W-1:0] rob_id;
    logic [CDB_PREG_W-1:0]   pd;
    logic [CDB_DATA_W-1:0]   data;
  } cdb_entry_t;

endpackage

`default_nettype wire

// File: rtl/cdb_writeback_arb_if.sv
// Per-way FU result inputs, CDB broadcast outputs and multiplier credit status.
`default_nettype none

interface cdb_writeback_arb_if #(
  parameter int SS       = 2,
  parameter int ROB_ID_W = 8,
  parameter int PREG_W   = 6,
  parameter int DATA_W   = 32
);

  logic [SS-1:0]               alu_valid;
  logic [SS-1:0][ROB_ID_W-1:0] alu_rob_id;
  logic [SS-1:0][PREG_W-1:0]   alu_pd;
  logic [SS-1:0][DATA_W-1:0]   alu_data;

  logic [SS-1:0]               mul_issue;
  logic [SS-1:0]               mul_valid;
  logic [SS-1:0][ROB_ID_W-1:0] mul_rob_id;
  logic [SS-1:0][PREG_W-1:0]   mul_pd;
  logic [SS-1:0][DATA_W-1:0]   mul_data;

  logic [SS-1:0]               cdb_valid;
  logic [SS-1:0][ROB_ID_W-1:0] cdb_rob_id;
  logic [SS-1:0][PREG_W-1:0]   cdb_pd;
  logic [SS-1:0][DATA_W-1:0]   cdb_data;
  logic [SS-1:0]               mul_ready;
  logic                        overflow_err;

  modport master (
    output alu_valid, alu_rob_id, alu_pd, alu_data,
    output mul_issue, mul_valid, mul_rob_id, mul_pd, mul_data,
    input  cdb_valid, cdb_rob_id, cdb_pd, cdb_data, mul_ready, overflow_err
  );

  modport slave (
    input  alu_valid, alu_rob_id, alu_pd, alu_data,
    input  mul_issue, mul_valid, mul_rob_id, mul_pd, mul_data,
    output cdb_valid, cdb_rob_id, cdb_pd, cdb_data, mul_ready, overflow_err
  );

endinterface

`default_nettype wire

// File: rtl/wb_lane.sv
// One CDB way: multiplier result FIFO, multiplier credit counter and ALU > FIFO > bypass mux.
`default_nettype none

module wb_lane
  import rv32i_types::*;
#(
  parameter int MUL_Q_DEPTH = MUL_Q_DEPTH_DFLT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       alu_valid,
  input  cdb_entry_t alu_entry,
  input  logic       mul_issue,
  input  logic       mul_valid,
  input  cdb_entry_t mul_entry,
  output logic       cdb_valid,
  output cdb_entry_t cdb_entry,
  output logic       mul_ready,
  output logic       overflow
);

  localparam int CNT_W = $clog2(MUL_Q_DEPTH + 1);
  localparam int PTR_W = $clog2(MUL_Q_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH    = CNT_W'(MUL_Q_DEPTH);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(MUL_Q_DEPTH - 1);

  cdb_entry_t        mem [MUL_Q_DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  inflight;

  logic              sel_valid;
  cdb_entry_t        sel_entry;
  logic              push;
  logic              push_ok;
  logic              pop;
  logic              drop;
  logic [CNT_W-1:0]  count_next;
  logic [CNT_W-1:0]  inflight_next;
  logic              ready_next;

  // Modulo wrap keeps non-power-of-two depths correct.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    sel_valid = 1'b0;
    sel_entry = mul_entry;
    push      = 1'b0;
    pop       = 1'b0;
    if (alu_valid) begin
      sel_valid = 1'b1;
      sel_entry = alu_entry;
      push      = mul_valid;
    end else if (count != '0) begin
      sel_valid = 1'b1;
      sel_entry = mem[head];
      pop       = 1'b1;
      push      = mul_valid;
    end else if (mul_valid) begin
      sel_valid = 1'b1;
      sel_entry = mul_entry;
    end

    // A full queue still accepts a push when the head leaves in the same cycle.
    drop       = push && (count == DEPTH) && !pop;
    push_ok    = push && !drop;
    count_next = count + CNT_W'(push_ok) - CNT_W'(pop);

    case ({mul_issue, mul_valid})
      2'b10:   inflight_next = inflight + CNT_W'(1);
      2'b01:   inflight_next = (inflight == '0) ? '0 : inflight - CNT_W'(1);
      default: inflight_next = inflight;
    endcase

    ready_next = ({1'b0, count_next} + {1'b0, inflight_next}) < {1'b0, DEPTH};
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[tail] <= mul_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_valid <= 1'b0;
      cdb_entry <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      inflight  <= '0;
      mul_ready <= 1'b1;
      overflow  <= 1'b0;
    end else begin
      cdb_valid <= sel_valid;
      if (sel_valid) begin
        cdb_entry <= sel_entry;
      end
      if (push_ok) begin
        tail <= next_ptr(tail);
      end
      if (pop) begin
        head <= next_ptr(head);
      end
      count     <= count_next;
      inflight  <= inflight_next;
      mul_ready <= ready_next;
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/cdb_writeback_arb.sv
// CDB writeback collector: one independent wb_lane per superscalar way.
`default_nettype none

module cdb_writeback_arb
  import rv32i_types::*;
#(
  parameter int SS          = 2,
  parameter int MUL_Q_DEPTH = MUL_Q_DEPTH_DFLT
) (
  input  logic               clk,
  input  logic               rst,
  cdb_writeback_arb_if.slave bus
);

  logic [SS-1:0] lane_ovf;

  for (genvar i = 0; i < SS; i++) begin : g_lane
    cdb_entry_t alu_e;
    cdb_entry_t mul_e;
    cdb_entry_t cdb_e;

    assign alu_e = {bus.alu_rob_id[i], bus.alu_pd[i], bus.alu_data[i]};
    assign mul_e = {bus.mul_rob_id[i], bus.mul_pd[i], bus.mul_data[i]};

    wb_lane #(
      .MUL_Q_DEPTH(MUL_Q_DEPTH)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .alu_valid (bus.alu_valid[i]),
      .alu_entry (alu_e),
      .mul_issue (bus.mul_issue[i]),
      .mul_valid (bus.mul_valid[i]),
      .mul_entry (mul_e),
      .cdb_valid (bus.cdb_valid[i]),
      .cdb_entry (cdb_e),
      .mul_ready (bus.mul_ready[i]),
      .overflow  (lane_ovf[i])
    );

    assign bus.cdb_rob_id[i] = cdb_e.rob_id;
    assign bus.cdb_pd[i]     = cdb_e.pd;
    assign bus.cdb_data[i]   = cdb_e.data;
  end

  assign bus.overflow_err = |lane_ovf;

endmodule

`default_nettype wire

// File: tb/tb_cdb_writeback_arb.sv
// Table-driven scoreboard bench for cdb_writeback_arb with reset and multi-cycle corner sequences.
`default_nettype none

module tb_cdb_writeback_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;

  cdb_writeback_arb_if #(.SS(2), .ROB_ID_W(8), .PREG_W(6), .DATA_W(32)) bus ();

  cdb_writeback_arb #(.SS(2), .MUL_Q_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       av;
    logic [7:0] arob;
    logic       mv;
    logic [7:0] mrob;
    logic       iss;
    logic       l1av;
    logic [7:0] l1rob;
    logic       ev;
    logic [7:0] erob;
    logic       erdy;
    logic       eovf;
  } vec_t;

  typedef struct {
    logic       ev;
    logic [7:0] erob;
    logic       erdy;
    logic       eovf;
    logic       l1v;
    logic [7:0] l1rob;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [7:0] last_rob;

  function automatic logic [5:0] pd_of(input logic [7:0] rob);
    return rob[5:0] ^ 6'h2A;
  endfunction

  function automatic logic [31:0] data_of(input logic [7:0] rob);
    return {rob, ~rob, rob, 8'h5A};
  endfunction

  function automatic vec_t mk(input logic av, input logic [7:0] arob, input logic mv,
                              input logic [7:0] mrob, input logic iss, input logic l1av,
                              input logic [7:0] l1rob, input logic ev, input logic [7:0] erob,
                              input logic erdy, input logic eovf);
    vec_t v;
    v.av = av; v.arob = arob; v.mv = mv; v.mrob = mrob; v.iss = iss;
    v.l1av = l1av; v.l1rob = l1rob; v.ev = ev; v.erob = erob; v.erdy = erdy; v.eovf = eovf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.alu_valid = '0; bus.alu_rob_id = '0; bus.alu_pd = '0; bus.alu_data = '0;
    bus.mul_issue = '0; bus.mul_valid  = '0; bus.mul_rob_id = '0; bus.mul_pd = '0;
    bus.mul_data  = '0;
  endtask

  task automatic drive(input vec_t v);
    idle_inputs();
    bus.alu_valid[0]  = v.av;
    bus.alu_rob_id[0] = v.arob;
    bus.alu_pd[0]     = pd_of(v.arob);
    bus.alu_data[0]   = data_of(v.arob);
    bus.mul_valid[0]  = v.mv;
    bus.mul_rob_id[0] = v.mrob;
    bus.mul_pd[0]     = pd_of(v.mrob);
    bus.mul_data[0]   = data_of(v.mrob);
    bus.mul_issue[0]  = v.iss;
    bus.alu_valid[1]  = v.l1av;
    bus.alu_rob_id[1] = v.l1rob;
    bus.alu_pd[1]     = pd_of(v.l1rob);
    bus.alu_data[1]   = data_of(v.l1rob);
  endtask

  task automatic compare(input exp_t e);
    chk("cdb_valid0", 32'(bus.cdb_valid[0]), 32'(e.ev));
    if (e.ev) begin
      chk("cdb_rob0", 32'(bus.cdb_rob_id[0]), 32'(e.erob));
      chk("cdb_pd0", 32'(bus.cdb_pd[0]), 32'(pd_of(e.erob)));
      chk("cdb_data0", bus.cdb_data[0], data_of(e.erob));
      last_rob = e.erob;
    end else begin
      chk("hold_rob0", 32'(bus.cdb_rob_id[0]), 32'(last_rob));
    end
    chk("mul_ready0", 32'(bus.mul_ready[0]), 32'(e.erdy));
    chk("overflow_err", 32'(bus.overflow_err), 32'(e.eovf));
    chk("cdb_valid1", 32'(bus.cdb_valid[1]), 32'(e.l1v));
    if (e.l1v) chk("cdb_rob1", 32'(bus.cdb_rob_id[1]), 32'(e.l1rob));
    chk("mul_ready1", 32'(bus.mul_ready[1]), 32'd1);
  endtask

  initial begin
    exp_t e;
    idle_inputs();

    // Collision on lane0, with an independent ALU result on lane1.
    vecs.push_back(mk(0,8'h00,0,8'h00,1, 0,8'h00, 0,8'h00,1,0));
    vecs.push_back(mk(1,8'h01,1,8'h02,0, 1,8'h77, 1,8'h01,1,0));
    vecs.push_back(mk(0,8'h00,0,8'h00,0, 0,8'h00, 1,8'h02,1,0));
    vecs.push_back(mk(0,8'h00,0,8'h00,0, 0,8'h00, 0,8'h00,1,0));
    // Credit stall then release via a bypassed result.
    vecs.push_back(mk(0,8'h00,0,8'h00,1, 0,8'h00, 0,8'h00,1,0));
    vecs.push_back(mk(0,8'h00,0,8'h00,1, 0,8'h00, 0,8'h00,1,0));
    vecs.push_back(mk(0,8'h00,0,8'h00,1, 0,8'h00, 0,8'h00,1,0));
    vecs.push_back(mk(0,8'h00,0,8'h00,1, 0,8'h00, 0,8'h00,0,0));
    vecs.push_back(mk(0,8'h00,1,8'h30,0, 0,8'h00, 1,8'h30,1,0));
    vecs.push_back(mk(0,8'h00,1,8'h31,0, 0,8'h00, 1,8'h31,1,0));
    vecs.push_back(mk(0,8'h00,1,8'h32,0, 0,8'h00, 1,8'h32,1,0));
    vecs.push_back(mk(0,8'h00,1,8'h33,0, 0,8'h00, 1,8'h33,1,0));
    // Drain under ALU pressure; 0x13 arrives mid-drain and must come out last.
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0,8'h00,0,8'h00,1, 0,8'h00, 0,8'h00,1,0));
    vecs.push_back(mk(0,8'h00,0,8'h00,1, 0,8'h00, 0,8'h00,0,0));
    vecs.push_back(mk(1,8'h40,1,8'h10,0, 0,8'h00, 1,8'h40,0,0));
    vecs.push_back(mk(1,8'h41,1,8'h11,0, 0,8'h00, 1,8'h41,0,0));
    vecs.push_back(mk(1,8'h42,1,8'h12,0, 0,8'h00, 1,8'h42,0,0));
    vecs.push_back(mk(1,8'h20,0,8'h00,0, 0,8'h00, 1,8'h20,0,0));
    vecs.push_back(mk(1,8'h21,0,8'h00,0, 0,8'h00, 1,8'h21,0,0));
    vecs.push_back(mk(0,8'h00,0,8'h00,0, 0,8'h00, 1,8'h10,1,0));
    vecs.push_back(mk(0,8'h00,1,8'h13,0, 0,8'h00, 1,8'h11,1,0));
    vecs.push_back(mk(0,8'h00,0,8'h00,0, 0,8'h00, 1,8'h12,1,0));
    vecs.push_back(mk(0,8'h00,0,8'h00,0, 0,8'h00, 1,8'h13,1,0));
    vecs.push_back(mk(0,8'h00,0,8'h00,0, 0,8'h00, 0,8'h00,1,0));
    // Fill to full, then push+pop at full across the pointer wrap.
    vecs.push_back(mk(1,8'h50,1,8'h60,0, 0,8'h00, 1,8'h50,1,0));
    vecs.push_back(mk(1,8'h51,1,8'h61,0, 0,8'h00, 1,8'h51,1,0));
    vecs.push_back(mk(1,8'h52,1,8'h62,0, 0,8'h00, 1,8'h52,1,0));
    vecs.push_back(mk(1,8'h53,1,8'h63,0, 0,8'h00, 1,8'h53,0,0));
    vecs.push_back(mk(0,8'h00,1,8'h64,0, 0,8'h00, 1,8'h60,0,0));
    vecs.push_back(mk(0,8'h00,1,8'h65,0, 0,8'h00, 1,8'h61,0,0));
    vecs.push_back(mk(0,8'h00,0,8'h00,0, 0,8'h00, 1,8'h62,1,0));
    vecs.push_back(mk(0,8'h00,0,8'h00,0, 0,8'h00, 1,8'h63,1,0));
    vecs.push_back(mk(0,8'h00,0,8'h00,0, 0,8'h00, 1,8'h64,1,0));
    vecs.push_back(mk(0,8'h00,0,8'h00,0, 0,8'h00, 1,8'h65,1,0));
    vecs.push_back(mk(0,8'h00,0,8'h00,0, 0,8'h00, 0,8'h00,1,0));
    // Overflow: push into a full queue while ALU blocks the pop; 0x84 is lost.
    vecs.push_back(mk(1,8'h70,1,8'h80,0, 0,8'h00, 1,8'h70,1,0));
    vecs.push_back(mk(1,8'h71,1,8'h81,0, 0,8'h00, 1,8'h71,1,0));
    vecs.push_back(mk(1,8'h72,1,8'h82,0, 0,8'h00, 1,8'h72,1,0));
    vecs.push_back(mk(1,8'h73,1,8'h83,0, 0,8'h00, 1,8'h73,0,0));
    vecs.push_back(mk(1,8'h74,1,8'h84,0, 0,8'h00, 1,8'h74,0,1));
    vecs.push_back(mk(0,8'h00,0,8'h00,0, 0,8'h00, 1,8'h80,1,1));
    vecs.push_back(mk(0,8'h00,0,8'h00,0, 0,8'h00, 1,8'h81,1,1));
    vecs.push_back(mk(0,8'h00,0,8'h00,0, 0,8'h00, 1,8'h82,1,1));
    vecs.push_back(mk(0,8'h00,0,8'h00,0, 0,8'h00, 1,8'h83,1,1));
    vecs.push_back(mk(0,8'h00,0,8'h00,0, 0,8'h00, 0,8'h00,1,1));
    // Setup for reset: 3 issued, two queued behind ALU, one still in flight.
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0,8'h00,0,8'h00,1, 0,8'h00, 0,8'h00,1,1));
    vecs.push_back(mk(1,8'h90,1,8'h91,0, 0,8'h00, 1,8'h90,1,1));
    vecs.push_back(mk(1,8'h92,1,8'h93,0, 0,8'h00, 1,8'h92,1,1));

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cdb_valid", 32'(bus.cdb_valid), 32'd0);
    chk("rst_cdb_rob0", 32'(bus.cdb_rob_id[0]), 32'd0);
    chk("rst_cdb_data0", bus.cdb_data[0], 32'd0);
    chk("rst_mul_ready", 32'(bus.mul_ready), 32'd3);
    chk("rst_overflow", 32'(bus.overflow_err), 32'd0);
    rst = 1'b0;

    // Single ALU result with explicit payload, then payload hold while idle.
    bus.alu_valid[0] = 1'b1; bus.alu_rob_id[0] = 8'h05;
    bus.alu_pd[0] = 6'd12; bus.alu_data[0] = 32'hDEADBEEF;
    @(posedge clk); #1;
    idle_inputs();
    chk("t1_valid0", 32'(bus.cdb_valid[0]), 32'd1);
    chk("t1_rob0", 32'(bus.cdb_rob_id[0]), 32'h05);
    chk("t1_pd0", 32'(bus.cdb_pd[0]), 32'd12);
    chk("t1_data0", bus.cdb_data[0], 32'hDEADBEEF);
    chk("t1_valid1", 32'(bus.cdb_valid[1]), 32'd0);
    @(posedge clk); #1;
    chk("t1_idle_valid0", 32'(bus.cdb_valid[0]), 32'd0);
    chk("t1_hold_data0", bus.cdb_data[0], 32'hDEADBEEF);
    last_rob = 8'h05;

    foreach (vecs[k]) begin
      drive(vecs[k]);
      e.ev = vecs[k].ev; e.erob = vecs[k].erob; e.erdy = vecs[k].erdy;
      e.eovf = vecs[k].eovf; e.l1v = vecs[k].l1av; e.l1rob = vecs[k].l1rob;
      exp_q.push_back(e);
      @(posedge clk); #1;
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL scoreboard: got empty queue expected entry");
      end else begin
        compare(exp_q.pop_front());
      end
    end

    // Reset mid-drain: queued 0x91/0x93 and the in-flight credit must vanish.
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("r_valid0", 32'(bus.cdb_valid[0]), 32'd0);
    chk("r_rob0", 32'(bus.cdb_rob_id[0]), 32'd0);
    chk("r_mul_ready0", 32'(bus.mul_ready[0]), 32'd1);
    chk("r_overflow", 32'(bus.overflow_err), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("r_no_stale_valid0", 32'(bus.cdb_valid[0]), 32'd0);
      chk("r_ready_after", 32'(bus.mul_ready[0]), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
